intr_stim_gen: RTL and testbench

Parametrised interrupt stimulus generator for CPU benches and on-board debug. It drives the CPU's active-low `irq` and `nmi` inputs from NUM_CH independently programmed channels, all timed against a shared cycle counter. Each channel supports one-shot windows, periodic bursts and assert-until-acknowledged. Acknowledge is detected by snooping the CPU address bus for the interrupt-vector fetch. The block replaces hand-written per-bench interrupt timing logic and is synthesisable.

---
 rtl/intr_stim_pkg.sv | 20 ++
 rtl/intr_stim_chan.sv | 110 +++++++++++
 rtl/intr_stim_gen.sv | 91 +++++++++
 tb/tb_intr_stim_gen.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_stim_pkg.sv
// Shared types and constants for the interrupt stimulus generator
// (channel modes, interrupt targets, CPU vector fetch addresses).
package intr_stim_pkg;

  typedef enum logic [1:0] {
    WINDOW    = 2'd0,
    PERIODIC  = 2'd1,
    UNTIL_ACK = 2'd2,
    OFF       = 2'd3
  } mode_e;

  typedef enum logic {
    IRQ = 1'b0,
    NMI = 1'b1
  } tgt_e;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

endpackage

// File: rtl/intr_stim_chan.sv
// One stimulus channel: configuration, periodic phase counter, ack latch and
// request. The ack latch and snoop inputs exist only with INTR_STIM_ACK_EN.
module intr_stim_chan
  import intr_stim_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_ph1,
  input  logic             rst,
`ifdef INTR_STIM_ACK_EN
  input  logic             hit_irq,
  input  logic             hit_nmi,
`endif
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  input  logic             cfg_sel,
  input  mode_e            cfg_mode,
  input  tgt_e             cfg_tgt,
  input  logic [CNT_W-1:0] cfg_start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_period,
  output logic             req_p0,
  output logic             act_p1,
  output logic             is_nmi
);

  mode_e            mode_r;
  tgt_e             tgt_r;
  logic [CNT_W-1:0] start_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] phase_r;
  logic             started;
  logic             in_win;
  logic             phase_adv;

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      mode_r <= OFF;
      tgt_r  <= IRQ;
    end else if (cfg_sel) begin
      mode_r <= cfg_mode;
      tgt_r  <= cfg_tgt;
    end
  end

  always_ff @(posedge clk_ph1) begin
    if (cfg_sel) begin
      start_r  <= cfg_start;
      len_r    <= cfg_len;
      period_r <= cfg_period;
    end
  end

  // Window end is compared one bit wider so start+len can never wrap
  assign started   = (cnt >= start_r);
  assign in_win    = started && ({1'b0, cnt} < ({1'b0, start_r} + {1'b0, len_r}));
  assign phase_adv = run && (mode_r == PERIODIC) && (period_r != '0) && started;
  assign is_nmi    = (tgt_r == NMI);

  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      phase_r <= '0;
    end else if (cfg_sel) begin
      phase_r <= '0;
    end else if (phase_adv) begin
      phase_r <= (phase_r == period_r - 1'b1) ? '0 : phase_r + 1'b1;
    end
  end

`ifdef INTR_STIM_ACK_EN
  logic ack_r;
  logic hit;

  assign hit = is_nmi ? hit_nmi : hit_irq;

  // Only an already-asserted channel can be acknowledged
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      ack_r <= 1'b0;
    end else if (cfg_sel) begin
      ack_r <= 1'b0;
    end else if ((mode_r == UNTIL_ACK) && act_p1 && hit) begin
      ack_r <= 1'b1;
    end
  end
`endif

  always_comb begin
    req_p0 = 1'b0;
    case (mode_r)
      WINDOW:    req_p0 = in_win;
      PERIODIC:  req_p0 = (period_r == '0) ? in_win : (started && (phase_r < len_r));
`ifdef INTR_STIM_ACK_EN
      UNTIL_ACK: req_p0 = started && !ack_r;
`endif
      default:   req_p0 = 1'b0;
    endcase
  end

  // Stage boundary: registered per-channel request
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      act_p1 <= 1'b0;
    end else begin
      act_p1 <= req_p0;
    end
  end

endmodule

// File: rtl/intr_stim_gen.sv
// Interrupt stimulus generator top: shared saturating cycle counter, config
// write decode, NUM_CH channels and registered active-low irq/nmi. Macro: INTR_STIM_ACK_EN.
module intr_stim_gen
  import intr_stim_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  CNT_W  = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_ph1,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_tgt,
  input  logic [CNT_W-1:0]  cfg_start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [15:0]       Addr_bus,
  input  logic              R_nW,
  output logic              irq,
  output logic              nmi,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [NUM_CH-1:0] ch_active
);

  logic [NUM_CH-1:0] req_p0;
  logic [NUM_CH-1:0] nmi_sel;

  // The counter saturates at all-ones rather than wrapping
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (run && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

`ifdef INTR_STIM_ACK_EN
  logic hit_irq;
  logic hit_nmi;

  assign hit_irq = R_nW && (Addr_bus == VEC_IRQ);
  assign hit_nmi = R_nW && (Addr_bus == VEC_NMI);
`else
  logic unused_bus;

  assign unused_bus = ^{Addr_bus, R_nW};
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic cfg_sel;

    assign cfg_sel = cfg_we && (cfg_ch == CH_W'(i));

    intr_stim_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk_ph1   (clk_ph1),
      .rst       (rst),
`ifdef INTR_STIM_ACK_EN
      .hit_irq   (hit_irq),
      .hit_nmi   (hit_nmi),
`endif
      .run       (run),
      .cnt       (cycle_count),
      .cfg_sel   (cfg_sel),
      .cfg_mode  (mode_e'(cfg_mode)),
      .cfg_tgt   (tgt_e'(cfg_tgt)),
      .cfg_start (cfg_start),
      .cfg_len   (cfg_len),
      .cfg_period(cfg_period),
      .req_p0    (req_p0[i]),
      .act_p1    (ch_active[i]),
      .is_nmi    (nmi_sel[i])
    );
  end

  // Stage boundary: wired-AND of active-low lines, registered with the requests
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      irq <= 1'b1;
      nmi <= 1'b1;
    end else begin
      irq <= ~|(req_p0 & ~nmi_sel);
      nmi <= ~|(req_p0 & nmi_sel);
    end
  end

endmodule

// File: tb/tb_intr_stim_gen.sv
// Bench for intr_stim_gen: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model; a CNT_W=4 instance covers saturation.
`timescale 1ns/1ps
module tb_intr_stim_gen;

  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;
`ifdef INTR_STIM_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic          clk_ph1 = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic          cfg_tgt = 1'b0;
  logic [CW-1:0] cfg_start = '0;
  logic [CW-1:0] cfg_len = '0;
  logic [CW-1:0] cfg_period = '0;
  logic [15:0]   Addr_bus = '0;
  logic          R_nW = 1'b0;
  logic          irq;
  logic          nmi;
  logic [CW-1:0] cycle_count;
  logic [NCH-1:0] ch_active;

  logic       run4 = 1'b0;
  logic       we4 = 1'b0;
  logic [0:0] ch4 = '0;
  logic [1:0] mode4 = '0;
  logic       tgt4 = 1'b0;
  logic [3:0] st4 = '0;
  logic [3:0] ln4 = '0;
  logic [3:0] pd4 = '0;
  logic       irq4;
  logic       nmi4;
  logic [3:0] cnt4;
  logic [0:0] act4;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  intr_stim_gen #(.NUM_CH(NCH), .CNT_W(CW)) u_dut (
    .clk_ph1(clk_ph1), .rst(rst), .run(run), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_tgt(cfg_tgt), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_period(cfg_period), .Addr_bus(Addr_bus), .R_nW(R_nW), .irq(irq), .nmi(nmi),
    .cycle_count(cycle_count), .ch_active(ch_active)
  );

  intr_stim_gen #(.NUM_CH(1), .CNT_W(4)) u_sat (
    .clk_ph1(clk_ph1), .rst(rst), .run(run4), .cfg_we(we4), .cfg_ch(ch4),
    .cfg_mode(mode4), .cfg_tgt(tgt4), .cfg_start(st4), .cfg_len(ln4),
    .cfg_period(pd4), .Addr_bus(Addr_bus), .R_nW(R_nW), .irq(irq4), .nmi(nmi4),
    .cycle_count(cnt4), .ch_active(act4)
  );

  always #5 clk_ph1 = ~clk_ph1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: evaluated at each falling edge from the inputs that
  // were held across the preceding rising edge.
  int   m_cnt;
  int   m_mode[NCH];
  int   m_tgt[NCH];
  int   m_start[NCH];
  int   m_len[NCH];
  int   m_per[NCH];
  int   m_k[NCH];
  bit   m_ack[NCH];
  logic [NCH-1:0] m_act;
  logic [NCH-1:0] m_r;
  logic m_irq;
  logic m_nmi;

  function automatic bit in_win(int c, int s, int l);
    return (c >= s) && (c < s + l);
  endfunction

  always begin
    @(negedge clk_ph1);
    if (rst) begin
      m_cnt = 0;
      m_act = '0;
      m_irq = 1'b1;
      m_nmi = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 3; m_tgt[i] = 0; m_k[i] = 0; m_ack[i] = 1'b0;
        m_start[i] = 0; m_len[i] = 0; m_per[i] = 0;
      end
    end else begin
      m_irq = 1'b1;
      m_nmi = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        case (m_mode[i])
          0: m_r[i] = in_win(m_cnt, m_start[i], m_len[i]);
          1: m_r[i] = (m_per[i] == 0) ? in_win(m_cnt, m_start[i], m_len[i])
                    : ((m_cnt >= m_start[i]) && ((m_k[i] % m_per[i]) < m_len[i]));
          2: m_r[i] = ACK_EN && (m_cnt >= m_start[i]) && !m_ack[i];
          default: m_r[i] = 1'b0;
        endcase
        if (m_r[i]) begin
          if (m_tgt[i] == 1) m_nmi = 1'b0;
          else m_irq = 1'b0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (cfg_we && (int'(cfg_ch) == i)) begin
          m_mode[i] = int'(cfg_mode); m_tgt[i] = int'(cfg_tgt);
          m_start[i] = int'(cfg_start); m_len[i] = int'(cfg_len); m_per[i] = int'(cfg_period);
          m_k[i] = 0; m_ack[i] = 1'b0;
        end else begin
          if (m_mode[i] == 1 && m_per[i] != 0 && run && m_cnt >= m_start[i]) m_k[i]++;
          if (ACK_EN && m_mode[i] == 2 && m_act[i] && R_nW &&
              Addr_bus == ((m_tgt[i] == 1) ? 16'hFFFA : 16'hFFFE)) m_ack[i] = 1'b1;
        end
      end
      m_act = m_r;
      if (run && m_cnt < CMAX) m_cnt++;
      if (chk_en) begin
        chk("model_irq", 32'(irq), 32'(m_irq));
        chk("model_nmi", 32'(nmi), 32'(m_nmi));
        chk("model_cnt", 32'(cycle_count), m_cnt);
        chk("model_act", 32'(ch_active), 32'(m_act));
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk_ph1);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; cfg_we = 1'b0; we4 = 1'b0; run4 = 1'b0;
    Addr_bus = '0; R_nW = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic cfg(int ch, int mode, int tgt, int s, int l, int p);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode); cfg_tgt = 1'(tgt);
    cfg_start = CW'(s); cfg_len = CW'(l); cfg_period = CW'(p);
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic wait_cnt(int v);
    int n = 0;
    while (int'(cycle_count) != v && n < 300) begin
      tick(1);
      n++;
    end
    chk("wait_cnt", 32'(cycle_count), v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int first;
    bit nmi_ok;
    bit irq_ok;
    bit wrapped;
    logic [31:0] mask;
    logic [3:0] prev4;

    // Reset values
    do_reset();
    chk_en = 1'b1;
    chk("rst_irq", 32'(irq), 32'd1);
    chk("rst_nmi", 32'(nmi), 32'd1);
    chk("rst_cnt", 32'(cycle_count), 32'd0);
    chk("rst_act", 32'(ch_active), 32'd0);

    // WINDOW on IRQ: start=5 len=15
    cfg(0, 0, 0, 5, 15, 0);
    run = 1'b1;
    lows = 0; first = -1; nmi_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (!irq) begin
        lows++;
        if (first < 0) first = int'(cycle_count);
      end
      if (!nmi) nmi_ok = 1'b0;
    end
    chk("win_len", lows, 15);
    chk("win_first_cnt", first, 6);
    chk("win_nmi_idle", 32'(nmi_ok), 32'd1);

    // PERIODIC on NMI: start=10 len=2 period=8, three periods
    do_reset();
    cfg(1, 1, 1, 10, 2, 8);
    run = 1'b1;
    mask = '0; irq_ok = 1'b1;
    for (int i = 0; i < 31; i++) begin
      tick(1);
      if (!nmi) mask[cycle_count[4:0]] = 1'b1;
      if (!irq) irq_ok = 1'b0;
    end
    chk("per_mask", mask, 32'h1818_1800);
    chk("per_irq_idle", 32'(irq_ok), 32'd1);

    // UNTIL_ACK on IRQ: start=3
    do_reset();
    cfg(2, 2, 0, 3, 0, 0);
    run = 1'b1;
    wait_cnt(8);
    chk("ua_hold", 32'(irq), ACK_EN ? 32'd0 : 32'd1);
    Addr_bus = 16'hFFFA; R_nW = 1'b1;
    tick(1);
    Addr_bus = 16'hFFFE; R_nW = 1'b0;
    tick(1);
    Addr_bus = 16'h1234; R_nW = 1'b1;
    tick(2);
    chk("ua_ignore_nmi_vec_and_write", 32'(irq), ACK_EN ? 32'd0 : 32'd1);
    Addr_bus = 16'hFFFE; R_nW = 1'b1;
    tick(1);
    chk("ua_fetch_sampled", 32'(irq), ACK_EN ? 32'd0 : 32'd1);
    Addr_bus = 16'h0000; R_nW = 1'b0;
    tick(1);
    chk("ua_released", 32'(irq), 32'd1);
    tick(5);
    chk("ua_stays_released", 32'(irq), 32'd1);

    // WINDOW ch0 + PERIODIC ch3, both IRQ, overlapping
    do_reset();
    cfg(0, 0, 0, 4, 10, 0);
    cfg(3, 1, 0, 6, 3, 5);
    run = 1'b1;
    wait_cnt(10);
    chk("ovl_act_a", 32'(ch_active), 32'b0001);
    chk("ovl_irq_a", 32'(irq), 32'd0);
    wait_cnt(12);
    chk("ovl_act_b", 32'(ch_active), 32'b1001);
    wait_cnt(16);
    chk("ovl_act_c", 32'(ch_active), 32'b0000);
    chk("ovl_irq_c", 32'(irq), 32'd1);
    wait_cnt(18);
    chk("ovl_act_d", 32'(ch_active), 32'b1000);
    chk("ovl_irq_d", 32'(irq), 32'd0);

    // Saturation with CNT_W=4: start=14 len=4
    do_reset();
    we4 = 1'b1; ch4 = '0; mode4 = 2'd0; tgt4 = 1'b0; st4 = 4'd14; ln4 = 4'd4; pd4 = 4'd0;
    tick(1);
    we4 = 1'b0; run4 = 1'b1;
    prev4 = '0; wrapped = 1'b0; first = -1;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      if (cnt4 < prev4) wrapped = 1'b1;
      prev4 = cnt4;
      if (!irq4 && first < 0) first = int'(cnt4);
    end
    chk("sat_cnt", 32'(cnt4), 32'd15);
    chk("sat_irq", 32'(irq4), 32'd0);
    chk("sat_act", 32'(act4), 32'd1);
    chk("sat_no_wrap", 32'(wrapped), 32'd0);
    chk("sat_first_cnt", first, 15);
    chk("sat_nmi", 32'(nmi4), 32'd1);

    // Asynchronous reset in the middle of an active window
    do_reset();
    cfg(0, 0, 0, 2, 100, 0);
    run = 1'b1;
    wait_cnt(10);
    chk("arst_before", 32'(irq), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_irq", 32'(irq), 32'd1);
    chk("arst_cnt", 32'(cycle_count), 32'd0);
    chk("arst_act", 32'(ch_active), 32'd0);
    @(negedge clk_ph1);
    #1;
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (!irq || ch_active != '0) lows++;
    end
    chk("arst_quiet_after", lows, 0);

    // Randomized traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int n = 0; n < 500; n++) begin
        cfg_we = ($urandom_range(0, 7) == 0);
        if (cfg_we) begin
          cfg_ch     = 2'($urandom_range(0, 3));
          cfg_mode   = 2'($urandom_range(0, 3));
          cfg_tgt    = 1'($urandom_range(0, 1));
          cfg_start  = CW'($urandom_range(0, 300));
          cfg_len    = CW'($urandom_range(0, 20));
          cfg_period = CW'($urandom_range(0, 12));
        end
        run = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 7))
          0:       Addr_bus = 16'hFFFE;
          1:       Addr_bus = 16'hFFFA;
          default: Addr_bus = 16'($urandom_range(0, 65535));
        endcase
        R_nW = 1'($urandom_range(0, 1));
        tick(1);
      end
      cfg_we = 1'b0;
    end
    tick(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
